// File: rtl/y86_pkg.sv
// Shared Y86 encodings used by the Execute stage.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned IFUN_W  = 4;
    localparam int unsigned STAT_W  = 3;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned CC_W    = 3;

    // Instruction codes handled here
    localparam logic [ICODE_W-1:0] I_NOP  = 4'h1;
    localparam logic [ICODE_W-1:0] I_CMOV = 4'h2;
    localparam logic [ICODE_W-1:0] I_OPQ  = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX  = 4'h7;

    // Status codes
    localparam logic [STAT_W-1:0] S_AOK = 3'd1;
    localparam logic [STAT_W-1:0] S_HLT = 3'd2;
    localparam logic [STAT_W-1:0] S_ADR = 3'd3;
    localparam logic [STAT_W-1:0] S_INS = 3'd4;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    // Condition-code bit positions in {OF,SF,ZF}
    localparam int unsigned CC_ZF = 0;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 2;

    // Condition selects for jXX / cmovXX
    localparam logic [IFUN_W-1:0] C_ALWAYS = 4'd0;
    localparam logic [IFUN_W-1:0] C_LE     = 4'd1;
    localparam logic [IFUN_W-1:0] C_L      = 4'd2;
    localparam logic [IFUN_W-1:0] C_E      = 4'd3;
    localparam logic [IFUN_W-1:0] C_NE     = 4'd4;
    localparam logic [IFUN_W-1:0] C_GE     = 4'd5;
    localparam logic [IFUN_W-1:0] C_G      = 4'd6;

    // Narrow control fields of the Execute->Memory register
    typedef struct packed {
        logic [ICODE_W-1:0] icode;
        logic               cnd;
        logic [STAT_W-1:0]  stat;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
        logic               valid;
    } m_ctl_t;

    localparam m_ctl_t M_CTL_BUBBLE = '{
        icode: I_NOP,
        cnd:   1'b0,
        stat:  S_AOK,
        dst_e: RNONE,
        dst_m: RNONE,
        valid: 1'b0
    };

endpackage

// File: rtl/cond_eval.sv
// Branch / conditional-move condition from the condition codes.
module cond_eval
    import y86_pkg::*;
(
    input  logic [CC_W-1:0]   cc,
    input  logic [IFUN_W-1:0] ifun,
    output logic              cnd
);

    logic lt;
    logic zf;

    assign lt = cc[CC_SF] ^ cc[CC_OF];
    assign zf = cc[CC_ZF];

    // Decode the condition select; unused selects never fire
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cc_pipe_reg.sv
// Condition-code register, condition evaluation and Execute->Memory register.
module execute_cc_pipe_reg
    import y86_pkg::*;
#(
    parameter int unsigned     W      = 64,
    parameter logic [CC_W-1:0] CC_RST = 3'b001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] e_icode,
    input  logic [IFUN_W-1:0]  e_ifun,
    input  logic [STAT_W-1:0]  e_stat,
    input  logic [W-1:0]       e_valE,
    input  logic [CC_W-1:0]    e_cf,
    input  logic [W-1:0]       e_valA,
    input  logic [REG_W-1:0]   e_dstE,
    input  logic [REG_W-1:0]   e_dstM,
    input  logic               e_stall,
    input  logic               m_bubble,
    input  logic               m_exc,
    input  logic               w_exc,
    output logic               e_cnd,
    output logic [CC_W-1:0]    cc_q,
    output logic [ICODE_W-1:0] M_icode,
    output logic               M_cnd,
    output logic [STAT_W-1:0]  M_stat,
    output logic [W-1:0]       M_valE,
    output logic [W-1:0]       M_valA,
    output logic [REG_W-1:0]   M_dstE,
    output logic [REG_W-1:0]   M_dstM,
    output logic               M_valid
);

    logic   set_cc_c;
    m_ctl_t m_ctl_q;
    m_ctl_t m_ctl_d;
    logic [W-1:0] m_val_e_q;
    logic [W-1:0] m_val_e_d;
    logic [W-1:0] m_val_a_q;
    logic [W-1:0] m_val_a_d;

    cond_eval u_cond_eval (
        .cc   (cc_q),
        .ifun (e_ifun),
        .cnd  (e_cnd)
    );

    // Only a clean, unstalled OPq with no older exception may write CC
    assign set_cc_c = (e_icode == I_OPQ) && (e_stat == S_AOK)
                      && !m_exc && !w_exc && !e_stall;

    // Condition-code register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= CC_RST;
        end else if (set_cc_c) begin
            cc_q <= e_cf;
        end
    end

    // Next M contents: stall holds, bubble clears, otherwise capture Execute
    always_comb begin
        m_ctl_d   = m_ctl_q;
        m_val_e_d = m_val_e_q;
        m_val_a_d = m_val_a_q;
        if (e_stall) begin
            m_ctl_d   = m_ctl_q;
        end else if (m_bubble) begin
            m_ctl_d   = M_CTL_BUBBLE;
            m_val_e_d = '0;
            m_val_a_d = '0;
        end else begin
            m_ctl_d.icode = e_icode;
            m_ctl_d.cnd   = e_cnd;
            m_ctl_d.stat  = e_stat;
            m_ctl_d.dst_e = ((e_icode == I_CMOV) && !e_cnd) ? RNONE : e_dstE;
            m_ctl_d.dst_m = e_dstM;
            m_ctl_d.valid = 1'b1;
            m_val_e_d     = e_valE;
            m_val_a_d     = e_valA;
        end
    end

    // Execute->Memory pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctl_q   <= M_CTL_BUBBLE;
            m_val_e_q <= '0;
            m_val_a_q <= '0;
        end else begin
            m_ctl_q   <= m_ctl_d;
            m_val_e_q <= m_val_e_d;
            m_val_a_q <= m_val_a_d;
        end
    end

    assign M_icode = m_ctl_q.icode;
    assign M_cnd   = m_ctl_q.cnd;
    assign M_stat  = m_ctl_q.stat;
    assign M_dstE  = m_ctl_q.dst_e;
    assign M_dstM  = m_ctl_q.dst_m;
    assign M_valid = m_ctl_q.valid;
    assign M_valE  = m_val_e_q;
    assign M_valA  = m_val_a_q;

endmodule

// File: tb/tb_execute_cc_pipe_reg.sv
// Directed bench for execute_cc_pipe_reg.
module tb_execute_cc_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [2:0]  e_stat;
    logic [63:0] e_valE;
    logic [2:0]  e_cf;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        e_stall;
    logic        m_bubble;
    logic        m_exc;
    logic        w_exc;
    logic        e_cnd;
    logic [2:0]  cc_q;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [2:0]  M_stat;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        M_valid;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_v;

    execute_cc_pipe_reg #(.W(64), .CC_RST(3'b001)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .e_icode  (e_icode),
        .e_ifun   (e_ifun),
        .e_stat   (e_stat),
        .e_valE   (e_valE),
        .e_cf     (e_cf),
        .e_valA   (e_valA),
        .e_dstE   (e_dstE),
        .e_dstM   (e_dstM),
        .e_stall  (e_stall),
        .m_bubble (m_bubble),
        .m_exc    (m_exc),
        .w_exc    (w_exc),
        .e_cnd    (e_cnd),
        .cc_q     (cc_q),
        .M_icode  (M_icode),
        .M_cnd    (M_cnd),
        .M_stat   (M_stat),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM),
        .M_valid  (M_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] stat,
                         input logic [2:0] cf, input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [3:0] dm);
        e_icode = icode; e_ifun = ifun; e_stat = stat; e_cf = cf;
        e_valE = va; e_valA = vb; e_dstE = de; e_dstM = dm;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        e_stall = 1'b0; m_bubble = 1'b0; m_exc = 1'b0; w_exc = 1'b0;
        drive(4'h1, 4'h0, 3'd1, 3'b000, 64'h0, 64'h0, 4'hF, 4'hF);

        // Reset state
        step(); step();
        chk("rst_cc", 64'(cc_q), 64'h1);
        chk("rst_icode", 64'(M_icode), 64'h1);
        chk("rst_dstE", 64'(M_dstE), 64'hF);
        chk("rst_valid", 64'(M_valid), 64'h0);

        // Release with stall: outputs stay put
        rst_n = 1'b1;
        e_stall = 1'b1;
        drive(4'h6, 4'h0, 3'd1, 3'b110, 64'hAAAA, 64'hBBBB, 4'h2, 4'hF);
        step();
        chk("rel_cc", 64'(cc_q), 64'h1);
        chk("rel_icode", 64'(M_icode), 64'h1);
        chk("rel_valid", 64'(M_valid), 64'h0);
        e_stall = 1'b0;

        // OPq sets SF
        drive(4'h6, 4'h0, 3'd1, 3'b010, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00, 4'h3, 4'hF);
        step();
        chk("opq_cc", 64'(cc_q), 64'h2);
        chk("opq_icode", 64'(M_icode), 64'h6);
        chk("opq_valE", M_valE, 64'h1122_3344_5566_7788);
        chk("opq_valA", M_valA, 64'h99AA_BBCC_DDEE_FF00);
        chk("opq_dstE", 64'(M_dstE), 64'h3);
        chk("opq_valid", 64'(M_valid), 64'h1);
        chk("opq_cnd", 64'(M_cnd), 64'h1);

        // jl after SF=1
        drive(4'h7, 4'h2, 3'd1, 3'b111, 64'h40, 64'h0, 4'hF, 4'hF);
        #1;
        chk("jl_ecnd", 64'(e_cnd), 64'h1);
        step();
        chk("jl_mcnd", 64'(M_cnd), 64'h1);
        chk("jl_icode", 64'(M_icode), 64'h7);
        chk("jl_cc", 64'(cc_q), 64'h2);

        // cmove with ZF=0 squashes dstE
        drive(4'h2, 4'h3, 3'd1, 3'b000, 64'h55, 64'h55, 4'h3, 4'hF);
        step();
        chk("cmov0_dstE", 64'(M_dstE), 64'hF);
        chk("cmov0_cnd", 64'(M_cnd), 64'h0);

        // Set ZF then cmove writes
        drive(4'h6, 4'h1, 3'd1, 3'b001, 64'h0, 64'h7, 4'h4, 4'hF);
        step();
        chk("zf_cc", 64'(cc_q), 64'h1);
        drive(4'h2, 4'h3, 3'd1, 3'b000, 64'h66, 64'h66, 4'h3, 4'hF);
        step();
        chk("cmov1_dstE", 64'(M_dstE), 64'h3);
        chk("cmov1_cnd", 64'(M_cnd), 64'h1);

        // Condition sweep at cc=001 (lt=0, ZF=1)
        e_stall = 1'b1;
        exp_v = 16'b0000_0000_0010_1011;
        drive(4'h1, 4'h0, 3'd1, 3'b000, 64'h0, 64'h0, 4'hF, 4'hF);
        for (int i = 0; i < 16; i++) begin
            e_ifun = 4'(i);
            #1;
            chk($sformatf("cnd_z_ifun%0d", i), 64'(e_cnd), 64'(exp_v[i]));
        end
        e_stall = 1'b0;
        step();

        // OPq sets OF
        drive(4'h6, 4'h0, 3'd1, 3'b100, 64'h10, 64'h20, 4'h5, 4'hF);
        step();
        chk("of_cc", 64'(cc_q), 64'h4);

        // Condition sweep at cc=100 (lt=1, ZF=0)
        e_stall = 1'b1;
        exp_v = 16'b0000_0000_0001_0111;
        drive(4'h1, 4'h0, 3'd1, 3'b000, 64'h0, 64'h0, 4'hF, 4'hF);
        for (int i = 0; i < 16; i++) begin
            e_ifun = 4'(i);
            #1;
            chk($sformatf("cnd_l_ifun%0d", i), 64'(e_cnd), 64'(exp_v[i]));
        end
        e_stall = 1'b0;
        step();

        // Older exceptions block CC but not M
        m_exc = 1'b1;
        drive(4'h6, 4'h0, 3'd1, 3'b001, 64'hC0DE, 64'h1, 4'h5, 4'hF);
        step();
        chk("mexc_cc", 64'(cc_q), 64'h4);
        chk("mexc_icode", 64'(M_icode), 64'h6);
        chk("mexc_dstE", 64'(M_dstE), 64'h5);
        m_exc = 1'b0;
        w_exc = 1'b1;
        drive(4'h6, 4'h0, 3'd1, 3'b010, 64'hC0DF, 64'h1, 4'h5, 4'hF);
        step();
        chk("wexc_cc", 64'(cc_q), 64'h4);
        chk("wexc_valE", M_valE, 64'hC0DF);
        w_exc = 1'b0;

        // Non-AOK OPq: CC kept, stat carried
        drive(4'h6, 4'h0, 3'd2, 3'b001, 64'hBEEF, 64'h2, 4'h5, 4'h6);
        step();
        chk("hlt_cc", 64'(cc_q), 64'h4);
        chk("hlt_stat", 64'(M_stat), 64'h2);
        chk("hlt_dstM", 64'(M_dstM), 64'h6);

        // Stalled OPq: CC and M held
        e_stall = 1'b1;
        drive(4'h6, 4'h0, 3'd1, 3'b001, 64'hDEAD, 64'h3, 4'h9, 4'h9);
        step();
        chk("stall_cc", 64'(cc_q), 64'h4);
        chk("stall_valE", M_valE, 64'hBEEF);
        chk("stall_dstE", 64'(M_dstE), 64'h5);
        chk("stall_stat", 64'(M_stat), 64'h2);

        // Stall beats bubble
        m_bubble = 1'b1;
        drive(4'h7, 4'h0, 3'd1, 3'b000, 64'h1, 64'h1, 4'hF, 4'hF);
        step();
        chk("stbub_icode", 64'(M_icode), 64'h6);
        chk("stbub_valid", 64'(M_valid), 64'h1);

        // Bubble alone
        e_stall = 1'b0;
        step();
        chk("bub_icode", 64'(M_icode), 64'h1);
        chk("bub_valid", 64'(M_valid), 64'h0);
        chk("bub_dstE", 64'(M_dstE), 64'hF);
        chk("bub_valE", M_valE, 64'h0);
        chk("bub_stat", 64'(M_stat), 64'h1);
        m_bubble = 1'b0;

        // Async reset mid-cycle
        drive(4'h6, 4'h0, 3'd1, 3'b010, 64'h11, 64'h22, 4'h1, 4'hF);
        step();
        chk("pre_cc1", 64'(cc_q), 64'h2);
        drive(4'h6, 4'h0, 3'd1, 3'b100, 64'h33, 64'h44, 4'h1, 4'hF);
        step();
        chk("pre_cc2", 64'(cc_q), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cc", 64'(cc_q), 64'h1);
        chk("arst_valid", 64'(M_valid), 64'h0);
        chk("arst_icode", 64'(M_icode), 64'h1);
        chk("arst_valE", M_valE, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
